vdp_cpu_port: RTL and testbench

Parametrised CPU-side bus port for the VDP core. It replaces the single-entry chip-select latch in the VDP top level with three pieces: a synchronised, glitch-filtered capture of `csr_n`/`csw_n`, a write/read command FIFO of configurable depth, and a req/ack issuer toward the VDP `REQ/WRT/ADR/DBO` inputs. It sits between the cartridge-bus pins and the VDP instance, in the `clk` (21 MHz pixel) domain.

---
 rtl/vdp_cpu_pkg.sv | 30 +++
 rtl/cs_glitch_filter.sv | 47 ++++
 rtl/vdp_cpu_port.sv | 195 +++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_cpu_pkg.sv
// Shared types and widths for the VDP CPU-side bus port.
//   cpu_cmd_t   : one queued bus command {wrt, adr, data}
//   bus_state_e : strobe capture FSM states
//   iss_state_e : command issuer FSM states
package vdp_cpu_pkg;

    localparam int unsigned CMD_ADDR_W = 2;
    localparam int unsigned CMD_DATA_W = 8;
    // Filter counter width; covers FILT_LEN up to 15.
    localparam int unsigned FILT_CNT_W = 4;

    typedef struct packed {
        logic                  wrt;
        logic [CMD_ADDR_W-1:0] adr;
        logic [CMD_DATA_W-1:0] data;
    } cpu_cmd_t;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_ACTIVE = 2'd1,
        BUS_ERR    = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        ISS_IDLE = 2'd0,
        ISS_REQ  = 2'd1,
        ISS_GAP  = 2'd2
    } iss_state_e;

endpackage

// File: rtl/cs_glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one
// active-low CPU strobe.
//   clk, reset_n : clock, async active-low reset
//   raw          : asynchronous strobe from the bus pin
//   filt         : filtered level (resets high)
module cs_glitch_filter
    import vdp_cpu_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filt
);

    logic                  sync1;
    logic                  sync2;
    logic [FILT_CNT_W-1:0] cnt;

    // Synchroniser; idles high like the strobe itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Level flips only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == FILT_CNT_W'(FILT_LEN - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + FILT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side bus port for the VDP: conditions csr_n/csw_n, queues one command
// per bus cycle in a FIFO, and issues them to the VDP with a req/ack handshake.
//   clk, reset_n          : clock, async active-low reset
//   csr_n, csw_n, mode, cdo : raw cartridge-bus inputs
//   cdi                   : VDP read data registered back to the CPU
//   req, wrt, adr, dbo, ack, dbi : VDP command interface
//   ovf_clr               : clears the sticky overflow/collision flags
//   overflow, collision   : sticky error flags
//   level                 : FIFO occupancy
module vdp_cpu_port
    import vdp_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = CMD_ADDR_W,
    parameter int unsigned DATA_W     = CMD_DATA_W,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        csr_n,
    input  logic                        csw_n,
    input  logic [ADDR_W-1:0]           mode,
    input  logic [DATA_W-1:0]           cdo,
    output logic [DATA_W-1:0]           cdi,
    output logic                        req,
    output logic                        wrt,
    output logic [ADDR_W-1:0]           adr,
    output logic [DATA_W-1:0]           dbo,
    input  logic                        ack,
    input  logic [DATA_W-1:0]           dbi,
    input  logic                        ovf_clr,
    output logic                        overflow,
    output logic                        collision,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic       r_filt;
    logic       w_filt;
    bus_state_e bus_state;
    iss_state_e iss_state;

    cpu_cmd_t   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic     r_low_c, w_low_c, both_low_c, both_high_c;
    logic     push_c, pop_c, full_c, wr_en_c;
    logic     coll_set_c, ovf_set_c;
    cpu_cmd_t cmd_in_c;
    cpu_cmd_t head_c;

    cs_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (csr_n),
        .filt    (r_filt)
    );

    cs_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (csw_n),
        .filt    (w_filt)
    );

    // Strobe decode, push/pop qualification and command capture.
    always_comb begin
        r_low_c     = ~r_filt;
        w_low_c     = ~w_filt;
        both_low_c  = r_low_c & w_low_c;
        both_high_c = r_filt & w_filt;
        // BUS_IDLE is only re-entered with both strobes high, so a low here is a fall.
        push_c      = (bus_state == BUS_IDLE) && (r_low_c ^ w_low_c);
        coll_set_c  = both_low_c && (bus_state != BUS_ERR);
        pop_c       = (iss_state == ISS_REQ) && ack;
        full_c      = (level == LVL_W'(FIFO_DEPTH));
        wr_en_c     = push_c && (!full_c || pop_c);
        ovf_set_c   = push_c && full_c && !pop_c;
        cmd_in_c.wrt  = w_low_c;
        cmd_in_c.adr  = CMD_ADDR_W'(mode);
        cmd_in_c.data = CMD_DATA_W'(cdo);
        head_c        = mem[rd_ptr];
    end

    // Bus FSM: one capture per strobe cycle, collision lock-out until idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_state <= BUS_IDLE;
        end else begin
            case (bus_state)
                BUS_IDLE: begin
                    if (both_low_c)
                        bus_state <= BUS_ERR;
                    else if (r_low_c || w_low_c)
                        bus_state <= BUS_ACTIVE;
                end
                BUS_ACTIVE: begin
                    if (both_low_c)
                        bus_state <= BUS_ERR;
                    else if (both_high_c)
                        bus_state <= BUS_IDLE;
                end
                BUS_ERR: begin
                    if (both_high_c)
                        bus_state <= BUS_IDLE;
                end
                default: bus_state <= BUS_IDLE;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_c)
            mem[wr_ptr] <= cmd_in_c;
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en_c)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en_c && !pop_c)
                level <= level + LVL_W'(1);
            else if (!wr_en_c && pop_c)
                level <= level - LVL_W'(1);
        end
    end

    // Issuer FSM: head entry is presented but only popped once acked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_state <= ISS_IDLE;
            req       <= 1'b0;
            wrt       <= 1'b0;
            adr       <= '0;
            dbo       <= '0;
        end else begin
            case (iss_state)
                ISS_IDLE: begin
                    if (level != '0) begin
                        req       <= 1'b1;
                        wrt       <= head_c.wrt;
                        adr       <= ADDR_W'(head_c.adr);
                        dbo       <= DATA_W'(head_c.data);
                        iss_state <= ISS_REQ;
                    end
                end
                ISS_REQ: begin
                    if (ack) begin
                        req       <= 1'b0;
                        iss_state <= ISS_GAP;
                    end
                end
                ISS_GAP:  iss_state <= ISS_IDLE;
                default:  iss_state <= ISS_IDLE;
            endcase
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (ovf_set_c)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (coll_set_c)
                collision <= 1'b1;
            else if (ovf_clr)
                collision <= 1'b0;
        end
    end

    // Read data return path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cdi <= '0;
        else
            cdi <= dbi;
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       csr_n, csw_n;
    logic [1:0] mode;
    logic [7:0] cdo, cdi, dbo, dbi;
    logic       req, wrt, ack, ovf_clr, overflow, collision;
    logic [1:0] adr;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    vdp_cpu_port #(.ADDR_W(2), .DATA_W(8), .FILT_LEN(3), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .csr_n     (csr_n),
        .csw_n     (csw_n),
        .mode      (mode),
        .cdo       (cdo),
        .cdi       (cdi),
        .req       (req),
        .wrt       (wrt),
        .adr       (adr),
        .dbo       (dbo),
        .ack       (ack),
        .dbi       (dbi),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .collision (collision),
        .level     (level)
    );

    always #5 clk = ~clk;

    // One strobe cycle driven from negedges: low for low_cyc, then high for 8.
    task automatic bus_cycle(input bit is_wr, input logic [1:0] m, input logic [7:0] d,
                             input int low_cyc);
        @(negedge clk);
        mode = m;
        cdo  = d;
        if (is_wr) csw_n = 1'b0; else csr_n = 1'b0;
        repeat (low_cyc) @(negedge clk);
        csw_n = 1'b1;
        csr_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (req !== 1'b0)       begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
        total++; if (wrt !== 1'b0)       begin bad++; $display("FAIL reset_wrt got=%b exp=0", wrt); end
        total++; if (adr !== 2'd0)       begin bad++; $display("FAIL reset_adr got=%h exp=0", adr); end
        total++; if (dbo !== 8'h00)      begin bad++; $display("FAIL reset_dbo got=%h exp=00", dbo); end
        total++; if (cdi !== 8'h00)      begin bad++; $display("FAIL reset_cdi got=%h exp=00", cdi); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_coll got=%b exp=0", collision); end
        total++; if (level !== 3'd0)     begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    endtask

    // Raw fall sampled by posedge 1 -> req high after posedge 7.
    task automatic test_latency();
        ack = 1'b1;
        @(negedge clk);
        mode  = 2'd1;
        cdo   = 8'h5A;
        csw_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) begin
                total++; if (level !== 3'd0) begin bad++; $display("FAIL lat_level_k5 got=%0d exp=0", level); end
            end
            if (k == 6) begin
                total++; if (req !== 1'b0)   begin bad++; $display("FAIL lat_req_early got=%b exp=0", req); end
                total++; if (level !== 3'd1) begin bad++; $display("FAIL lat_level_push got=%0d exp=1", level); end
            end
            if (k == 7) begin
                total++; if (req !== 1'b1)   begin bad++; $display("FAIL lat_req got=%b exp=1", req); end
                total++; if (wrt !== 1'b1)   begin bad++; $display("FAIL lat_wrt got=%b exp=1", wrt); end
                total++; if (adr !== 2'd1)   begin bad++; $display("FAIL lat_adr got=%h exp=1", adr); end
                total++; if (dbo !== 8'h5A)  begin bad++; $display("FAIL lat_dbo got=%h exp=5a", dbo); end
            end
            if (k == 8) begin
                total++; if (req !== 1'b0)   begin bad++; $display("FAIL lat_req_drop got=%b exp=0", req); end
                total++; if (level !== 3'd0) begin bad++; $display("FAIL lat_level_pop got=%0d exp=0", level); end
            end
        end
        csw_n = 1'b1;
        repeat (10) @(negedge clk);
        // Long strobe must have produced only one command.
        total++; if (level !== 3'd0) begin bad++; $display("FAIL lat_single_push got=%0d exp=0", level); end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        @(negedge clk);
        csw_n = 1'b0;
        repeat (2) @(negedge clk);
        csw_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req !== 1'b0 || level !== 3'd0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_activity got=%b exp=0", seen); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL glitch_level got=%0d exp=0", level); end
    endtask

    // Five writes with ack low, then drain: order, spacing and drop of the fifth.
    task automatic test_overflow();
        logic [7:0] got_d [$];
        logic [1:0] got_a [$];
        int         got_t [$];
        ack = 1'b0;
        for (int i = 0; i < 5; i++) bus_cycle(1'b1, 2'(i), 8'(8'h10 + i), 6);
        @(negedge clk);
        total++; if (level !== 3'd4)   begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (req !== 1'b1)     begin bad++; $display("FAIL ovf_req_held got=%b exp=1", req); end
        for (int k = 0; k < 20; k++) begin
            if (req === 1'b1) begin
                got_d.push_back(dbo);
                got_a.push_back(adr);
                got_t.push_back(k);
            end
            ack = 1'b1;
            @(negedge clk);
        end
        total++; if (got_d.size() !== 4) begin bad++; $display("FAIL drain_count got=%0d exp=4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL drain_dbo%0d got=%h exp=%h", i, got_d[i], 8'(8'h10 + i)); end
            total++; if (got_a[i] !== 2'(i))         begin bad++; $display("FAIL drain_adr%0d got=%h exp=%h", i, got_a[i], 2'(i)); end
            if (i > 0) begin
                total++; if (got_t[i] - got_t[i-1] !== 3) begin bad++; $display("FAIL drain_spacing%0d got=%0d exp=3", i, got_t[i] - got_t[i-1]); end
            end
        end
        total++; if (level !== 3'd0)   begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_collision();
        bit seen = 1'b0;
        logic       r_wrt;
        logic [1:0] r_adr;
        ack = 1'b1;
        @(negedge clk);
        csr_n = 1'b0;
        csw_n = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 6) begin csr_n = 1'b1; csw_n = 1'b1; end
            if (req !== 1'b0 || level !== 3'd0) seen = 1'b1;
        end
        total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_flag got=%b exp=1", collision); end
        total++; if (seen !== 1'b0)      begin bad++; $display("FAIL coll_push got=%b exp=0", seen); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b exp=0", collision); end
        // Clean read afterwards.
        seen = 1'b0;
        @(negedge clk);
        mode  = 2'd2;
        cdo   = 8'h77;
        csr_n = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 6) csr_n = 1'b1;
            if (req === 1'b1 && !seen) begin seen = 1'b1; r_wrt = wrt; r_adr = adr; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rd_issued got=%b exp=1", seen); end
        if (seen) begin
            total++; if (r_wrt !== 1'b0) begin bad++; $display("FAIL rd_wrt got=%b exp=0", r_wrt); end
            total++; if (r_adr !== 2'd2) begin bad++; $display("FAIL rd_adr got=%h exp=2", r_adr); end
        end
        dbi = 8'hC3;
        @(negedge clk);
        total++; if (cdi !== 8'hC3) begin bad++; $display("FAIL cdi_reg got=%h exp=c3", cdi); end
    endtask

    // Fill FIFO, then land a push and an acked pop on the same edge.
    task automatic test_full_push_pop();
        ack = 1'b0;
        for (int i = 0; i < 4; i++) bus_cycle(1'b1, 2'(i), 8'(8'h20 + i), 6);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_fill got=%0d exp=4", level); end
        @(negedge clk);
        mode  = 2'd3;
        cdo   = 8'hEE;
        csw_n = 1'b0;
        repeat (5) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        total++; if (level !== 3'd4)    begin bad++; $display("FAIL full_pushpop_level got=%0d exp=4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
        repeat (3) @(negedge clk);
        csw_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (req !== 1'b1)   begin bad++; $display("FAIL mid_req_pre got=%b exp=1", req); end
        total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_level_pre got=%0d exp=3", level); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (req !== 1'b0)   begin bad++; $display("FAIL mid_req_async got=%b exp=0", req); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_level_async got=%0d exp=0", level); end
        @(negedge clk);
        reset_n = 1'b1;
        ack = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (req !== 1'b0 || level !== 3'd0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_stale_issue got=%b exp=0", seen); end
    endtask

    initial begin
        reset_n = 1'b0;
        csr_n   = 1'b1;
        csw_n   = 1'b1;
        mode    = 2'd0;
        cdo     = 8'h00;
        ack     = 1'b0;
        dbi     = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_latency();
        test_glitch();
        test_overflow();
        test_collision();
        test_full_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
